smpl_iter_gen: RTL and testbench

//  Sample iterator/jitter generator: producer of the sample stream that the sample-count and jitter-hash

---
 rtl/smpl_iter_gen.sv | 149 ++++++++++++++
 tb/tb_smpl_iter_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smpl_iter_gen.sv
// Sample iterator: walks a grid-aligned bounding box in subsample steps (x fastest) and emits one
// sample per unstalled cycle. Define SMPL_ITER_JITTER_EN to add hashed per-sample jitter.
module smpl_iter_gen #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic [3:0]               subSample_RnnnnU,
  input  logic                     halt_RnnnnL,
  output logic                     halt_R13L,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic signed [7:0]        jitter_x_R14S,
  output logic signed [7:0]        jitter_y_R14S,
  output logic signed [SIGFIG-1:0] s_j_x_R14S,
  output logic signed [SIGFIG-1:0] s_j_y_R14S,
  output logic                     validSamp_R14H,
  output logic [0:0]               state_dbg
);

  // Handshakes: a box is taken on a rising edge where validTri_R13H, halt_R13L and halt_RnnnnL
  // are all high; a sample is consumed on each rising edge where validSamp_R14H and halt_RnnnnL
  // are high. While halt_RnnnnL is low every register holds.

  localparam logic [0:0] WAIT = 1'b0;
  localparam logic [0:0] TEST = 1'b1;

  logic [0:0]               state;
  logic signed [SIGFIG-1:0] cur_x, cur_y, ll_x, ur_x, ur_y;
  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic [1:0]               ss_lg2, ss_dec;

  logic signed [SIGFIG:0]   step, nx, ny, urx_e, ury_e;
  logic                     x_ok, y_ok;
  logic signed [7:0]        jit_x, jit_y;
  logic signed [SIGFIG-1:0] sj_x, sj_y;

  assign halt_R13L = (state == WAIT);
  assign state_dbg = state;

  always_comb begin
    case (subSample_RnnnnU)
      4'b0001: ss_dec = 2'd3;
      4'b0010: ss_dec = 2'd2;
      4'b0100: ss_dec = 2'd1;
      default: ss_dec = 2'd0;
    endcase
  end

  // Cursor arithmetic is one bit wider than positions so boxes near the top never wrap.
  always_comb begin
    step  = {{SIGFIG{1'b0}}, 1'b1} << (RADIX - 32'(ss_lg2));
    nx    = {cur_x[SIGFIG-1], cur_x};
    nx    = nx + step;
    ny    = {cur_y[SIGFIG-1], cur_y};
    ny    = ny + step;
    urx_e = {ur_x[SIGFIG-1], ur_x};
    ury_e = {ur_y[SIGFIG-1], ur_y};
    x_ok  = (nx <= urx_e);
    y_ok  = (ny <= ury_e);
  end

`ifdef SMPL_ITER_JITTER_EN
  logic [15:0]              key, h;
  logic signed [SIGFIG-1:0] ext_x, ext_y, off_x, off_y;

  always_comb begin
    key   = cur_x[15:0] ^ {cur_y[7:0], cur_y[15:8]};
    h     = key * 16'h9E37;
    jit_x = h[7:0];
    jit_y = h[15:8];
    ext_x = {{(SIGFIG-8){jit_x[7]}}, jit_x};
    ext_y = {{(SIGFIG-8){jit_y[7]}}, jit_y};
    off_x = (ext_x <<< (RADIX - 8)) >>> ss_lg2;
    off_y = (ext_y <<< (RADIX - 8)) >>> ss_lg2;
    sj_x  = cur_x + off_x;
    sj_y  = cur_y + off_y;
  end
`else
  always_comb begin
    jit_x = '0;
    jit_y = '0;
    sj_x  = cur_x;
    sj_y  = cur_y;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT;
      validSamp_R14H <= 1'b0;
      tri_R14S       <= '{default: '0};
      sample_R14S    <= '{default: '0};
      jitter_x_R14S  <= '0;
      jitter_y_R14S  <= '0;
      s_j_x_R14S     <= '0;
      s_j_y_R14S     <= '0;
      tri_q          <= '{default: '0};
      cur_x          <= '0;
      cur_y          <= '0;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      ss_lg2         <= '0;
    end else if (halt_RnnnnL) begin
      case (state)
        WAIT: begin
          validSamp_R14H <= 1'b0;
          if (validTri_R13H) begin
            tri_q  <= tri_R13S;
            ll_x   <= box_R13S[0][0];
            ur_x   <= box_R13S[1][0];
            ur_y   <= box_R13S[1][1];
            cur_x  <= box_R13S[0][0];
            cur_y  <= box_R13S[0][1];
            ss_lg2 <= ss_dec;
            state  <= TEST;
          end
        end
        TEST: begin
          validSamp_R14H <= 1'b1;
          tri_R14S       <= tri_q;
          sample_R14S[0] <= cur_x;
          sample_R14S[1] <= cur_y;
          jitter_x_R14S  <= jit_x;
          jitter_y_R14S  <= jit_y;
          s_j_x_R14S     <= sj_x;
          s_j_y_R14S     <= sj_y;
          if (x_ok) begin
            cur_x <= nx[SIGFIG-1:0];
          end else if (y_ok) begin
            cur_x <= ll_x;
            cur_y <= ny[SIGFIG-1:0];
          end else begin
            state <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_smpl_iter_gen.sv
// Bench for smpl_iter_gen: randomized boxes and stalls, expected samples from a loop-based model,
// checked in order by an independent monitor.
`timescale 1ns/1ps
module tb_smpl_iter_gen;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int W      = 6 * SIGFIG + 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
  logic signed [SIGFIG-1:0] box_R13S [2][2];
  logic                     validTri_R13H;
  logic [3:0]               subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic                     halt_R13L;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic signed [7:0]        jitter_x_R14S, jitter_y_R14S;
  logic signed [SIGFIG-1:0] s_j_x_R14S, s_j_y_R14S;
  logic                     validSamp_R14H;
  logic [0:0]               state_dbg;

  smpl_iter_gen #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)) dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_R13S), .box_R13S(box_R13S),
    .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
    .halt_RnnnnL(halt_RnnnnL), .halt_R13L(halt_R13L), .tri_R14S(tri_R14S),
    .sample_R14S(sample_R14S), .jitter_x_R14S(jitter_x_R14S), .jitter_y_R14S(jitter_y_R14S),
    .s_j_x_R14S(s_j_x_R14S), .s_j_y_R14S(s_j_y_R14S), .validSamp_R14H(validSamp_R14H),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         samples_seen = 0;
  logic [W-1:0] exp_q[$];
  bit         rand_stall = 1'b0;
  bit         force_halt = 1'b1;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {sample_R14S[0], sample_R14S[1], jitter_x_R14S, jitter_y_R14S,
            s_j_x_R14S, s_j_y_R14S, tri_R14S[0][0], tri_R14S[VERTS-1][AXIS-1]};
  endfunction

  // Reference: expected output for one grid point, from the hash/offset rules in plain integers.
  function automatic logic [W-1:0] model(input int x, input int y, input int lg2,
                                         input logic [SIGFIG-1:0] t0, input logic [SIGFIG-1:0] t1);
    int jx, jy, ox, oy;
    longint key, h;
    jx = 0;
    jy = 0;
    key = 0;
    h = 0;
`ifdef SMPL_ITER_JITTER_EN
    key = longint'((x & 'hFFFF) ^ (((y & 'hFF) << 8) | ((y >>> 8) & 'hFF)));
    h   = (key * 40503) % 65536;
    jx  = int'(h % 256);
    jy  = int'(h / 256);
    if (jx > 127) jx -= 256;
    if (jy > 127) jy -= 256;
`endif
    ox = (jx * (1 << (RADIX - 8))) >>> lg2;
    oy = (jy * (1 << (RADIX - 8))) >>> lg2;
    return {SIGFIG'(x), SIGFIG'(y), 8'(jx), 8'(jy), SIGFIG'(x + ox), SIGFIG'(y + oy), t0, t1};
  endfunction

  // ---------------- driver tasks ----------------
  initial begin
    halt_RnnnnL = 1'b1;
    forever begin
      @(negedge clk);
      halt_RnnnnL = rand_stall ? ($urandom_range(0, 3) != 0) : force_halt;
    end
  end

  task automatic send_box(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] ss, input bit use_model,
                          input logic [SIGFIG-1:0] t0, input logic [SIGFIG-1:0] t1);
    int lg2, step;
    bit acc;
    lg2  = ss[0] ? 3 : ss[1] ? 2 : ss[2] ? 1 : 0;
    step = 1 << (RADIX - lg2);
    @(negedge clk);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_R13S[v][a] = SIGFIG'($urandom);
    tri_R13S[0][0]             = t0;
    tri_R13S[VERTS-1][AXIS-1]  = t1;
    box_R13S[0][0]   = SIGFIG'(llx);
    box_R13S[0][1]   = SIGFIG'(lly);
    box_R13S[1][0]   = SIGFIG'(urx);
    box_R13S[1][1]   = SIGFIG'(ury);
    subSample_RnnnnU = ss;
    validTri_R13H    = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 3000 && !acc; c++) begin
      #2;
      acc = halt_R13L && halt_RnnnnL;
      @(negedge clk);
    end
    validTri_R13H = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 3000 cycles");
    end else if (use_model) begin
      for (int y = lly; y <= ury; y += step)
        for (int x = llx; x <= urx; x += step)
          exp_q.push_back(model(x, y, lg2, t0, t1));
    end
  endtask

  task automatic wait_seen(input int target, input string name);
    int n;
    n = 0;
    while (samples_seen < target && n < 500) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (samples_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d samples expected %0d", name, samples_seen, target);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W:0]   prev_v;
    logic [W-1:0] exp;
    bit           prev_stalled;
    prev_stalled = 1'b0;
    prev_v = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) check("stall_hold", {validSamp_R14H, dut_vec()}, prev_v);
        if (validSamp_R14H && halt_RnnnnL) begin
          samples_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got %h expected no sample", dut_vec());
          end else begin
            exp = exp_q.pop_front();
            check("sample", {1'b0, dut_vec()}, {1'b0, exp});
          end
        end
        prev_stalled = validSamp_R14H && !halt_RnnnnL;
        prev_v = {validSamp_R14H, dut_vec()};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, n;
    int llx, lly, sx, sy;
    logic [3:0] ss;
    rst = 1'b1;
    validTri_R13H = 1'b0;
    subSample_RnnnnU = 4'b1000;
    box_R13S = '{default: '0};
    tri_R13S = '{default: '0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_valid", W'(validSamp_R14H), W'(0));
    check("reset_halt", W'(halt_R13L), W'(1));
    check("reset_data", {1'b0, dut_vec()}, '0);

    // Box 1: 2x2 points, then latency and ready checks.
    base = samples_seen;
    send_box(0, 0, 1024, 1024, 4'b1000, 1'b1, 24'h000111, 24'h000222);
    #2;
    check("lat_wait_valid", W'(validSamp_R14H), W'(0));
    check("busy_halt", W'(halt_R13L), W'(0));
    @(negedge clk);
    #2;
    check("first_valid", W'(validSamp_R14H), W'(1));
    check("first_xy", W'({sample_R14S[0], sample_R14S[1]}), W'(0));
    wait_seen(base + 4, "box1_count");
    @(negedge clk);
    #2;
    check("done_valid", W'(validSamp_R14H), W'(0));
    check("done_halt", W'(halt_R13L), W'(1));

    // Single point boxes.
    send_box(2048, 512, 2048, 512, 4'b0001 << $urandom_range(0, 3), 1'b1, 24'h00ABCD, 24'h123456);
`ifdef SMPL_ITER_JITTER_EN
    exp_q.push_back({24'd1024, 24'd0, 8'h00, 8'hDC, 24'd1024, -24'sd144, 24'h000333, 24'h000444});
`else
    exp_q.push_back({24'd1024, 24'd0, 8'h00, 8'h00, 24'd1024, 24'd0, 24'h000333, 24'h000444});
`endif
    send_box(1024, 0, 1024, 0, 4'b1000, 1'b0, 24'h000333, 24'h000444);
    repeat (6) @(negedge clk);

    // Stall for 3 cycles mid-box; count must still be 4.
    base = samples_seen;
    send_box(0, 0, 1024, 1024, 4'b1000, 1'b1, 24'h000555, 24'h000666);
    wait_seen(base + 1, "stall_first");
    force_halt = 1'b0;
    repeat (3) @(negedge clk);
    #1 force_halt = 1'b1;
    repeat (12) @(negedge clk);
    #3;
    check("stall_count", W'(samples_seen - base), W'(4));

    // Reset during the second sample aborts the box.
    base = samples_seen;
    send_box(0, 0, 1024, 1024, 4'b1000, 1'b1, 24'h000777, 24'h000888);
    wait_seen(base + 1, "rst_first");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_valid", W'(validSamp_R14H), W'(0));
    check("rst_halt", W'(halt_R13L), W'(1));
    send_box(1024, 2048, 2048, 2048, 4'b0100, 1'b1, 24'h000999, 24'h000AAA);

    // Randomized boxes with random downstream stalls.
    rand_stall = 1'b1;
    for (int b = 0; b < 25; b++) begin
      llx = int'($urandom_range(0, 8)) * 1024 - 4096;
      lly = int'($urandom_range(0, 8)) * 1024 - 4096;
      sx  = int'($urandom_range(0, 2)) * 1024;
      sy  = int'($urandom_range(0, 2)) * 1024;
      ss  = 4'b0001 << $urandom_range(0, 3);
      send_box(llx, lly, llx + sx, lly + sy, ss, 1'b1, SIGFIG'($urandom), SIGFIG'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("queue_empty", W'(exp_q.size()), W'(0));
    rand_stall = 1'b0;
    force_halt = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("idle_valid", W'(validSamp_R14H), W'(0));
    check("idle_halt", W'(halt_R13L), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
